// File: rtl/lcd_arbiter_if.sv
// LCD bus as seen between the arbiter (master) and lcd_interface (slave).
interface lcd_arbiter_if;
  logic        if_we;
  logic        if_wr;
  logic        if_rs;
  logic [15:0] if_data;
  logic        if_busy;
  logic        if_ok;

  modport master (output if_we, if_wr, if_rs, if_data, input if_busy, if_ok);
  modport slave  (input if_we, if_wr, if_rs, if_data, output if_busy, if_ok);
endinterface

// File: rtl/lcd_arbiter.sv
// Shares the LCD bus between the init sequencer, the CPU and the fill engine.
// Optional macro LCD_ARB_FILL_EN enables arbitration of the fill-engine port.
module lcd_arbiter #(
  parameter int MAX_BURST     = 64,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        init_finish,
  input  logic        init_we,
  input  logic        init_wr,
  input  logic        init_rs,
  input  logic [15:0] init_data,
  output logic        init_ok,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_wr,
  input  logic        cpu_rs,
  input  logic [15:0] cpu_data,
  output logic        cpu_gnt,
  output logic        cpu_busy,
  output logic        cpu_ok,
  input  logic        fill_req,
  input  logic        fill_we,
  input  logic        fill_rs,
  input  logic [15:0] fill_data,
  output logic        fill_gnt,
  output logic        fill_busy,
  output logic        fill_ok,
  lcd_arbiter_if.master lcd
);
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SETTLE, ST_GRANT} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  burst_q, burst_d;
  logic        cpu_gnt_q, cpu_gnt_d;
  logic        fill_gnt_q, fill_gnt_d;

  logic        fill_req_eff;
  logic        limit_en;
  logic        own_req, other_req;
  logic        own_we, own_wr, own_rs;
  logic [15:0] own_data;
  logic        own_busy, own_ok;

`ifdef LCD_ARB_FILL_EN
  assign fill_req_eff = fill_req;
  assign limit_en     = 1'b1;
`else
  logic unused_fill_req;
  assign unused_fill_req = fill_req;
  assign fill_req_eff    = 1'b0;
  assign limit_en        = 1'b0;
`endif

  always_comb begin
    own_req   = owner_q ? fill_req_eff : cpu_req;
    other_req = owner_q ? cpu_req : fill_req_eff;
    own_we    = owner_q ? fill_we : cpu_we;
    own_wr    = owner_q ? 1'b1 : cpu_wr;
    own_rs    = owner_q ? fill_rs : cpu_rs;
    own_data  = owner_q ? fill_data : cpu_data;
  end

  // Bus routing and per-port status are combinational from state and owner.
  always_comb begin
    lcd.if_we   = 1'b0;
    lcd.if_wr   = 1'b1;
    lcd.if_rs   = 1'b0;
    lcd.if_data = 16'h0000;
    init_ok     = 1'b0;
    own_busy    = 1'b1;
    own_ok      = 1'b0;
    cpu_busy    = 1'b1;
    cpu_ok      = 1'b0;
    fill_busy   = 1'b1;
    fill_ok     = 1'b0;
    case (state_q)
      ST_INIT: begin
        lcd.if_we   = init_we;
        lcd.if_wr   = init_wr;
        lcd.if_rs   = init_rs;
        lcd.if_data = init_data;
        init_ok     = lcd.if_ok;
      end
      ST_SETTLE: begin
        lcd.if_wr   = own_wr;
        lcd.if_rs   = own_rs;
        lcd.if_data = own_data;
      end
      ST_GRANT: begin
        lcd.if_we   = own_we;
        lcd.if_wr   = own_wr;
        lcd.if_rs   = own_rs;
        lcd.if_data = own_data;
        // A pending re-init stalls the owner while its last transfer drains.
        own_busy    = init_finish ? lcd.if_busy : 1'b1;
        own_ok      = lcd.if_ok;
      end
      default: ;
    endcase
    if (state_q == ST_SETTLE || state_q == ST_GRANT) begin
      if (owner_q) begin
        fill_busy = own_busy;
        fill_ok   = own_ok;
      end else begin
        cpu_busy  = own_busy;
        cpu_ok    = own_ok;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    settle_d = settle_q;
    burst_d  = burst_q;
    case (state_q)
      ST_INIT: begin
        if (init_finish) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!init_finish) begin
          state_d = ST_INIT;
        end else if (cpu_req || fill_req_eff) begin
          // On a tie, the requester that did not own the bus last wins.
          owner_d  = (cpu_req && fill_req_eff) ? ~last_q : fill_req_eff;
          settle_d = SETTLE_LD;
          burst_d  = 8'd0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (!init_finish) state_d = ST_INIT;
        else if (settle_q <= 4'd1) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (lcd.if_ok && burst_q != BURST_MAX) burst_d = burst_q + 8'd1;
        if (!init_finish) begin
          if (!lcd.if_busy) state_d = ST_INIT;
        end else if (!lcd.if_busy && !lcd.if_we &&
                     (!own_req || (limit_en && burst_q == BURST_MAX && other_req))) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_INIT;
    endcase
    cpu_gnt_d  = (state_d == ST_SETTLE || state_d == ST_GRANT) && !owner_d;
    fill_gnt_d = (state_d == ST_SETTLE || state_d == ST_GRANT) &&  owner_d;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      settle_q   <= 4'd0;
      burst_q    <= 8'd0;
      cpu_gnt_q  <= 1'b0;
      fill_gnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      settle_q   <= settle_d;
      burst_q    <= burst_d;
      cpu_gnt_q  <= cpu_gnt_d;
      fill_gnt_q <= fill_gnt_d;
    end
  end

  assign cpu_gnt  = cpu_gnt_q;
  assign fill_gnt = fill_gnt_q;
endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed bench for lcd_arbiter; fill-port scenarios run when LCD_ARB_FILL_EN is defined.
module tb_lcd_arbiter;
  localparam int MAX_BURST     = 4;
  localparam int SETTLE_CYCLES = 1;

  logic        pclk = 1'b0;
  logic        rst;
  logic        init_finish, init_we, init_wr, init_rs;
  logic [15:0] init_data;
  logic        init_ok;
  logic        cpu_req, cpu_we, cpu_wr, cpu_rs;
  logic [15:0] cpu_data;
  logic        cpu_gnt, cpu_busy, cpu_ok;
  logic        fill_req, fill_we, fill_rs;
  logic [15:0] fill_data;
  logic        fill_gnt, fill_busy, fill_ok;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cpu_oks  = 0;
  int fill_oks = 0;
  logic [15:0] exp_q[$];

  lcd_arbiter_if lcd ();

  always #5 pclk = ~pclk;

  lcd_arbiter #(.MAX_BURST(MAX_BURST), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .pclk(pclk), .rst(rst),
    .init_finish(init_finish), .init_we(init_we), .init_wr(init_wr),
    .init_rs(init_rs), .init_data(init_data), .init_ok(init_ok),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wr(cpu_wr), .cpu_rs(cpu_rs),
    .cpu_data(cpu_data), .cpu_gnt(cpu_gnt), .cpu_busy(cpu_busy), .cpu_ok(cpu_ok),
    .fill_req(fill_req), .fill_we(fill_we), .fill_rs(fill_rs),
    .fill_data(fill_data), .fill_gnt(fill_gnt), .fill_busy(fill_busy), .fill_ok(fill_ok),
    .lcd(lcd)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check_pop(input string tag);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 16'(exp_q.size()), 16'd1);
    else check(tag, lcd.if_data, exp_q.pop_front());
  endtask

  task automatic cpu_write(input logic [15:0] d);
    cpu_we = 1'b1; cpu_wr = 1'b1; cpu_rs = d[0]; cpu_data = d;
    exp_q.push_back(d);
    #1;
    check("cpu_if_we", lcd.if_we, 1'b1);
    check("cpu_if_rs", lcd.if_rs, d[0]);
    check_pop("cpu_if_data");
    tick(); cpu_we = 1'b0; lcd.if_busy = 1'b1;
    #1 check("cpu_busy_hi", cpu_busy, 1'b1);
    tick(); lcd.if_busy = 1'b0; lcd.if_ok = 1'b1;
    #1 check("cpu_busy_lo", cpu_busy, 1'b0);
    check("cpu_fill_ok", fill_ok, 1'b0);
    if (cpu_ok === 1'b1) cpu_oks++;
    tick(); lcd.if_ok = 1'b0;
  endtask

  task automatic fill_write(input logic [15:0] d);
    fill_we = 1'b1; fill_rs = d[1]; fill_data = d;
    exp_q.push_back(d);
    #1;
    check("fill_if_we", lcd.if_we, 1'b1);
    check("fill_if_wr", lcd.if_wr, 1'b1);
    check("fill_if_rs", lcd.if_rs, d[1]);
    check_pop("fill_if_data");
    tick(); fill_we = 1'b0; lcd.if_busy = 1'b1;
    tick(); lcd.if_busy = 1'b0; lcd.if_ok = 1'b1;
    #1 check("fill_busy_lo", fill_busy, 1'b0);
    check("fill_cpu_ok", cpu_ok, 1'b0);
    if (fill_ok === 1'b1) fill_oks++;
    tick(); lcd.if_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_finish = 1'b0; init_we = 1'b0; init_wr = 1'b1; init_rs = 1'b0;
    init_data = 16'h0000; cpu_req = 1'b0; cpu_we = 1'b0; cpu_wr = 1'b1; cpu_rs = 1'b0;
    cpu_data = 16'h0000; fill_req = 1'b0; fill_we = 1'b0; fill_rs = 1'b0; fill_data = 16'h0000;
    lcd.if_busy = 1'b0; lcd.if_ok = 1'b0;
    tick(); tick(); rst = 1'b0;

    // Reset state and INIT pass-through
    #1;
    check("rst_cpu_gnt", cpu_gnt, 1'b0);
    check("rst_fill_gnt", fill_gnt, 1'b0);
    check("rst_cpu_busy", cpu_busy, 1'b1);
    check("rst_fill_busy", fill_busy, 1'b1);
    check("rst_cpu_ok", cpu_ok, 1'b0);
    check("rst_fill_ok", fill_ok, 1'b0);
    init_we = 1'b1; init_wr = 1'b0; init_rs = 1'b1; init_data = 16'hA5C3;
    exp_q.push_back(init_data);
    lcd.if_ok = 1'b1;
    #1;
    check("init_if_we", lcd.if_we, 1'b1);
    check("init_if_wr", lcd.if_wr, 1'b0);
    check("init_if_rs", lcd.if_rs, 1'b1);
    check_pop("init_if_data");
    check("init_ok_hi", init_ok, 1'b1);
    check("init_cpu_ok", cpu_ok, 1'b0);
    tick(); init_we = 1'b0; init_data = 16'h1234; lcd.if_ok = 1'b0;
    #1;
    check("init_if_we_lo", lcd.if_we, 1'b0);
    check("init_if_data2", lcd.if_data, 16'h1234);
    check("init_ok_lo", init_ok, 1'b0);

    // init_finish -> IDLE on the next cycle; bus parked
    init_finish = 1'b1; init_we = 1'b1;
    tick(); lcd.if_ok = 1'b1;
    #1;
    check("idle_if_we", lcd.if_we, 1'b0);
    check("idle_if_wr", lcd.if_wr, 1'b1);
    check("idle_if_data", lcd.if_data, 16'h0000);
    check("idle_init_ok", init_ok, 1'b0);
    lcd.if_ok = 1'b0; init_we = 1'b0;

`ifndef LCD_ARB_FILL_EN
    fill_req = 1'b1; fill_we = 1'b1; fill_data = 16'hDEAD;
`endif

    // CPU grant latency and settle masking
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_data = 16'h0F0F;
    #1 check("cpu_gnt_before", cpu_gnt, 1'b0);
    tick();
    #1;
    check("settle_cpu_gnt", cpu_gnt, 1'b1);
    check("settle_cpu_busy", cpu_busy, 1'b1);
    check("settle_if_we", lcd.if_we, 1'b0);
    check("settle_fill_gnt", fill_gnt, 1'b0);
    cpu_we = 1'b0;
    tick();
    #1;
    check("grant_cpu_gnt", cpu_gnt, 1'b1);
    check("grant_cpu_busy", cpu_busy, 1'b0);
    lcd.if_busy = 1'b1;
    #1 check("grant_cpu_busy_f", cpu_busy, 1'b1);
    lcd.if_busy = 1'b0;

    for (int i = 0; i < 10; i++) cpu_write(16'h1000 + 16'(i) * 16'h0111);
    check("cpu_ok_count", 16'(cpu_oks), 16'd10);
    check("cpu_fill_gnt", fill_gnt, 1'b0);

    cpu_req = 1'b0;
    tick();
    #1;
    check("rel_cpu_gnt", cpu_gnt, 1'b0);
    check("rel_cpu_busy", cpu_busy, 1'b1);
    tick();
    #1 check("idle_fill_gnt", fill_gnt, 1'b0);

    // Owner drops req mid-transfer: held until if_busy falls
    cpu_req = 1'b1;
    tick(); tick();
    lcd.if_busy = 1'b1; cpu_req = 1'b0;
    tick();
    #1 check("hold_cpu_gnt", cpu_gnt, 1'b1);
    lcd.if_busy = 1'b0;
    tick();
    #1 check("drop_cpu_gnt", cpu_gnt, 1'b0);

`ifdef LCD_ARB_FILL_EN
    // Tie after reset goes to the CPU
    rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    cpu_req = 1'b1; fill_req = 1'b1;
    tick();
    #1;
    check("tie_cpu_gnt", cpu_gnt, 1'b1);
    check("tie_fill_gnt", fill_gnt, 1'b0);
    check("tie_fill_busy", fill_busy, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) cpu_write(16'h2000 + 16'(i));
    cpu_req = 1'b0;
    tick();
    #1;
    check("gap_cpu_gnt", cpu_gnt, 1'b0);
    check("gap_fill_gnt", fill_gnt, 1'b0);
    tick();
    #1 check("hand_fill_gnt", fill_gnt, 1'b1);
    tick();
    #1 check("fill_grant_busy", fill_busy, 1'b0);

    // Burst limit: fill releases after MAX_BURST completions while CPU waits
    cpu_req = 1'b1; cpu_wr = 1'b0;
    for (int i = 0; i < 3; i++) fill_write(16'h3000 + 16'(i) * 16'h0102);
    tick();
    #1 check("burst3_fill_gnt", fill_gnt, 1'b1);
    fill_write(16'h3ABC);
    tick();
    #1;
    check("burst_rel_fill", fill_gnt, 1'b0);
    check("burst_rel_cpu", cpu_gnt, 1'b0);
    tick();
    #1 check("burst_cpu_gnt", cpu_gnt, 1'b1);
    tick();
    cpu_write(16'hC0DE);
    cpu_req = 1'b0;
    tick(); tick();
    #1;
    check("regrant_fill", fill_gnt, 1'b1);
    check("fill_ok_count", 16'(fill_oks), 16'd4);
    tick();
    fill_req = 1'b0;
    tick();
    #1 check("fill_rel", fill_gnt, 1'b0);
`endif

    // Re-init while a transfer is in flight
    cpu_req = 1'b1;
    tick(); tick();
    lcd.if_busy = 1'b1; init_finish = 1'b0;
    tick();
    #1 check("reinit_hold_gnt", cpu_gnt, 1'b1);
    lcd.if_busy = 1'b0;
    #1 check("reinit_busy", cpu_busy, 1'b1);
    tick();
    init_we = 1'b1; init_data = 16'h5A5A;
    #1;
    check("reinit_cpu_gnt", cpu_gnt, 1'b0);
    check("reinit_cpu_busy", cpu_busy, 1'b1);
    check("reinit_if_data", lcd.if_data, 16'h5A5A);
    check("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
